keypad_scan_ctrl: RTL and testbench

//  Sequencing controller for the 4x4 matrix-keypad column sweep. Drives one column
//  low at a time and samples the row inputs. Debounces press and release, then

---
 rtl/keypad_scan_ctrl_if.sv | 19 +
 rtl/keypad_scan_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/keypad_scan_ctrl_if.sv
// Key-result bundle from the keypad scanner to downstream logic
// (key decoder, LED/display). Master drives, slave observes.
interface keypad_scan_ctrl_if;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  modport master (
    output key_code,
    output key_valid,
    output key_held
  );

  modport slave (
    input key_code,
    input key_valid,
    input key_held
  );
endinterface

// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix-keypad column sweep: one column driven low per slot, rows sampled at
// slot end, debounced press/release, one key code reported per accepted press.
module keypad_scan_ctrl #(
  parameter int SCAN_DIV       = 27_000,
  parameter int DEBOUNCE_TICKS = 4
) (
  input  logic               clk,
  input  logic               n_reset,
  input  logic [3:0]         filas,
  output logic [3:0]         columnas,
  keypad_scan_ctrl_if.master key_if
);
  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_TICKS);

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_HELD,
    ST_RELEASE
  } state_t;

  logic [3:0]       filas_meta_reg;
  logic [3:0]       rs_reg;
  logic [DIV_W-1:0] div_reg;
  logic             tick;

  state_t           state_reg, state_next;
  logic [3:0]       columnas_reg, columnas_next;
  logic [3:0]       pat_reg, pat_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [3:0]       key_code_reg, key_code_next;
  logic             key_valid_reg, key_valid_next;
  logic             key_held_reg, key_held_next;

  logic [3:0]       rs_low;
  logic             single;
  logic [1:0]       row_idx;
  logic [3:0]       col_low;
  logic [1:0]       col_idx;
  logic [3:0]       columnas_rot;
  logic [CNT_W-1:0] cnt_inc;
  logic             accept;
  logic             release_key;

  // Rows come straight off pulled-up pins, so they idle high through reset.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      filas_meta_reg <= 4'b1111;
      rs_reg         <= 4'b1111;
    end else begin
      filas_meta_reg <= filas;
      rs_reg         <= filas_meta_reg;
    end
  end

  assign tick = (div_reg == DIV_LAST);

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      div_reg <= '0;
    end else if (tick) begin
      div_reg <= '0;
    end else begin
      div_reg <= div_reg + 1'b1;
    end
  end

  // Exactly one row low means one key; zero or several are treated as no key.
  assign rs_low  = ~rs_reg;
  assign single  = (rs_low != 4'b0000) && ((rs_low & 4'(rs_low - 4'd1)) == 4'b0000);
  assign row_idx = {rs_low[3] | rs_low[2], rs_low[3] | rs_low[1]};

  assign col_low      = ~columnas_reg;
  assign col_idx      = {col_low[3] | col_low[2], col_low[3] | col_low[1]};
  assign columnas_rot = {columnas_reg[2:0], columnas_reg[3]};
  assign cnt_inc      = cnt_reg + 1'b1;

  always_comb begin
    state_next     = state_reg;
    columnas_next  = columnas_reg;
    pat_next       = pat_reg;
    cnt_next       = cnt_reg;
    key_code_next  = key_code_reg;
    key_valid_next = 1'b0;
    key_held_next  = key_held_reg;
    accept         = 1'b0;
    release_key    = 1'b0;

    if (tick) begin
      case (state_reg)
        ST_SCAN: begin
          if (single) begin
            pat_next = rs_reg;
            cnt_next = CNT_ONE;
            if (DEBOUNCE_TICKS == 1) begin
              accept = 1'b1;
            end else begin
              state_next = ST_DEBOUNCE;
            end
          end else begin
            columnas_next = columnas_rot;
          end
        end
        ST_DEBOUNCE: begin
          if (rs_reg == pat_reg) begin
            cnt_next = cnt_inc;
            if (cnt_inc == CNT_DONE) begin
              accept = 1'b1;
            end
          end else begin
            state_next    = ST_SCAN;
            columnas_next = columnas_rot;
          end
        end
        ST_HELD: begin
          // Any deviation on the frozen column, including another key, starts release.
          if (rs_reg != pat_reg) begin
            cnt_next = CNT_ONE;
            if (DEBOUNCE_TICKS == 1) begin
              release_key = 1'b1;
            end else begin
              state_next = ST_RELEASE;
            end
          end
        end
        ST_RELEASE: begin
          if (rs_reg == pat_reg) begin
            state_next = ST_HELD;
          end else begin
            cnt_next = cnt_inc;
            if (cnt_inc == CNT_DONE) begin
              release_key = 1'b1;
            end
          end
        end
        default: begin
          state_next = ST_SCAN;
        end
      endcase
    end

    // At accept the synced rows still equal the latched pattern, so rs gives the row.
    if (accept) begin
      key_code_next  = {row_idx, col_idx};
      key_valid_next = 1'b1;
      key_held_next  = 1'b1;
      state_next     = ST_HELD;
    end

    if (release_key) begin
      key_held_next = 1'b0;
      state_next    = ST_SCAN;
      columnas_next = columnas_rot;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_reg     <= ST_SCAN;
      columnas_reg  <= 4'b1110;
      pat_reg       <= 4'b1111;
      cnt_reg       <= '0;
      key_code_reg  <= 4'h0;
      key_valid_reg <= 1'b0;
      key_held_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      columnas_reg  <= columnas_next;
      pat_reg       <= pat_next;
      cnt_reg       <= cnt_next;
      key_code_reg  <= key_code_next;
      key_valid_reg <= key_valid_next;
      key_held_reg  <= key_held_next;
    end
  end

  assign columnas         = columnas_reg;
  assign key_if.key_code  = key_code_reg;
  assign key_if.key_valid = key_valid_reg;
  assign key_if.key_held  = key_held_reg;
endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: a simulated keypad matrix, a tick-level behavioural
// model feeding a scoreboard queue, and a negedge monitor that checks the DUT.
module tb_keypad_scan_ctrl;
  localparam int SCAN_DIV = 4;
  localparam int DEB      = 3;

  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic [3:0]  filas;
  logic [3:0]  columnas;
  logic [15:0] keys = '0;   // bit {row,col} set = that key is pressed

  keypad_scan_ctrl_if kif ();

  keypad_scan_ctrl #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_TICKS (DEB)
  ) dut (
    .clk      (clk),
    .n_reset  (n_reset),
    .filas    (filas),
    .columnas (columnas),
    .key_if   (kif)
  );

  always #5 clk = ~clk;

  // Keypad matrix: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    filas = 4'b1111;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (!columnas[c] && keys[r*4+c]) filas[r] = 1'b0;
      end
    end
  end

  typedef struct {
    logic [3:0] code;
    int         due;
  } exp_t;

  exp_t       sb_q[$];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  int         n_pushed = 0;
  int         n_seen = 0;
  logic [3:0] exp_col = 4'b1110;
  logic       exp_held = 1'b0;
  logic [3:0] exp_code = 4'h0;

  // Model: which column is being looked at, what phase of key handling, a
  // stable-tick count and the row pattern of the tracked key.
  int         m_col = 0;
  int         m_phase = 0;   // 0 sweeping, 1 confirming press, 2 key down, 3 confirming release
  int         m_n = 0;
  logic [3:0] m_lat = 4'hF;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [3:0] act, logic [3:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endfunction

  function automatic logic [3:0] rows_seen(logic [15:0] k, int col);
    logic [3:0] p;
    p = 4'b1111;
    for (int r = 0; r < 4; r++) if (k[r*4+col]) p[r] = 1'b0;
    return p;
  endfunction

  function automatic int low_row(logic [3:0] p);
    int idx;
    idx = 0;
    for (int r = 0; r < 4; r++) if (!p[r]) idx = r;
    return idx;
  endfunction

  task automatic model_accept();
    exp_t e;
    exp_code = 4'((low_row(m_lat) << 2) | m_col);
    exp_held = 1'b1;
    m_phase  = 2;
    e.code   = exp_code;
    e.due    = cyc;
    sb_q.push_back(e);
    n_pushed++;
  endtask

  task automatic model_step();
    logic [3:0] p;
    p = rows_seen(keys, m_col);
    case (m_phase)
      0: begin
        if ($countones(~p) == 1) begin
          m_lat = p; m_n = 1; m_phase = 1;
          if (m_n == DEB) model_accept();
        end else begin
          m_col = (m_col + 1) % 4;
        end
      end
      1: begin
        if (p == m_lat) begin
          m_n++;
          if (m_n == DEB) model_accept();
        end else begin
          m_phase = 0; m_col = (m_col + 1) % 4;
        end
      end
      2: begin
        if (p != m_lat) begin m_n = 1; m_phase = 3; end
      end
      default: begin
        if (p == m_lat) begin
          m_phase = 2;
        end else begin
          m_n++;
          if (m_n == DEB) begin
            exp_held = 1'b0; m_phase = 0; m_col = (m_col + 1) % 4;
          end
        end
      end
    endcase
    exp_col = ~(4'b0001 << m_col);
  endtask

  task automatic model_reset();
    sb_q.delete();
    m_col = 0; m_phase = 0; m_n = 0; m_lat = 4'hF;
    exp_col = 4'b1110; exp_held = 1'b0; exp_code = 4'h0;
  endtask

  // Wait out one column slot and advance the model at the tick edge.
  task automatic tick_step();
    repeat (SCAN_DIV) @(posedge clk);
    #1;
    model_step();
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    n_reset = 1'b1;
  endtask

  // Monitor: compares visible state every cycle and consumes one scoreboard
  // entry per key_valid pulse.
  always @(negedge clk) begin
    exp_t e;
    check("columnas", columnas, exp_col);
    check("key_held", {3'b000, kif.key_held}, {3'b000, exp_held});
    check("key_code", kif.key_code, exp_code);
    if (kif.key_valid) begin
      n_seen++;
      if (sb_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL key_valid_unexpected: got pulse code=%h expected none (t=%0t)", kif.key_code, $time);
      end else begin
        e = sb_q.pop_front();
        $display("key_valid code=%h expected=%h cycle=%0d", kif.key_code, e.code, cyc);
        check("pulse_code", kif.key_code, e.code);
        checks++;
        if (e.due != cyc) begin
          errors++;
          $display("FAIL pulse_cycle: got cycle %0d expected %0d", cyc, e.due);
        end
      end
    end
    while (sb_q.size() > 0 && sb_q[0].due < cyc) begin
      e = sb_q.pop_front();
      checks++; errors++;
      $display("FAIL key_valid_missing: got no pulse expected code=%h at cycle %0d", e.code, e.due);
    end
  end

  initial begin
    model_reset();
    release_reset();

    // Idle sweep over two full rotations.
    repeat (8) tick_step();

    // Press row 2 / col 1 and hold; release after.
    keys = 16'(1) << 9;
    repeat (10) tick_step();
    keys = '0;
    repeat (6) tick_step();

    // One-slot glitch on the same key while column 1 is being driven.
    for (int i = 0; i < 8 && m_col != 1; i++) tick_step();
    keys = 16'(1) << 9;
    tick_step();
    keys = '0;
    repeat (4) tick_step();

    // Release bounce: one tick open, then pressed again.
    keys = 16'(1) << 9;
    repeat (10) tick_step();
    keys = '0;
    tick_step();
    keys = 16'(1) << 9;
    repeat (4) tick_step();
    keys = '0;
    repeat (6) tick_step();

    // Two rows on one column: ignored.
    keys = (16'(1) << 9) | (16'(1) << 5);
    repeat (10) tick_step();
    keys = '0;
    repeat (2) tick_step();

    // Asynchronous reset while a key is held.
    keys = 16'(1) << 9;
    repeat (10) tick_step();
    @(posedge clk);
    #2;
    n_reset = 1'b0;
    #1;
    check("async_columnas", columnas, 4'b1110);
    check("async_key_held", {3'b000, kif.key_held}, 4'h0);
    check("async_key_valid", {3'b000, kif.key_valid}, 4'h0);
    check("async_key_code", kif.key_code, 4'h0);
    model_reset();
    keys = '0;
    release_reset();

    // Random presses: none, one key, or two keys, changing now and then.
    repeat (300) begin
      if ($urandom_range(0, 5) == 0) begin
        case ($urandom_range(0, 3))
          0:       keys = '0;
          1, 2:    keys = 16'(1) << $urandom_range(0, 15);
          default: keys = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
        endcase
      end
      tick_step();
    end
    keys = '0;
    repeat (8) tick_step();
    @(negedge clk);
    #1;

    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    checks++;
    if (n_seen != n_pushed || n_pushed == 0) begin
      errors++;
      $display("FAIL pulse_count: got %0d pulses expected %0d (nonzero)", n_seen, n_pushed);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
